// File: rtl/gpu_l2_req_responder_if.sv
// Purpose : Bundles the cluster-side request/response bus and the memory
//           back-end req/gnt/rvalid bus of the L2 request responder.
// Ports   : cl_read_i/cl_write_i/cl_addr_i/cl_wdata_i  cluster requests
//           cl_ready_o/cl_rdata_o                      cluster responses
//           mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  back-end request
//           mem_gnt_i/mem_rvalid_i/mem_rdata_i         back-end response
//           Suffixes are from the responder's point of view.
// Modports: slave  - the responder (gpu_l2_req_responder)
//           master - the environment (clusters + back end)
interface gpu_l2_req_responder_if #(
  parameter int NUM_CLIENTS = 2,
  parameter int DATA_W      = 256,
  parameter int ADDR_W      = 32
);
  logic [NUM_CLIENTS-1:0]        cl_read_i;
  logic [NUM_CLIENTS-1:0]        cl_write_i;
  logic [NUM_CLIENTS*DATA_W-1:0] cl_addr_i;
  logic [NUM_CLIENTS*DATA_W-1:0] cl_wdata_i;
  logic [NUM_CLIENTS-1:0]        cl_ready_o;
  logic [NUM_CLIENTS*DATA_W-1:0] cl_rdata_o;
  logic                          mem_req_o;
  logic                          mem_we_o;
  logic [ADDR_W-1:0]             mem_addr_o;
  logic [DATA_W-1:0]             mem_wdata_o;
  logic                          mem_gnt_i;
  logic                          mem_rvalid_i;
  logic [DATA_W-1:0]             mem_rdata_i;

  modport slave (
    input  cl_read_i, cl_write_i, cl_addr_i, cl_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output cl_ready_o, cl_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output cl_read_i, cl_write_i, cl_addr_i, cl_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  cl_ready_o, cl_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/gpu_l2_req_responder.sv
// Purpose : L2-side responder for the shader-cluster request bus. Arbitrates
//           two clusters round-robin, runs one transaction at a time on a
//           req/gnt/rvalid back end, then pulses ready (with read data) to the
//           winning cluster for one cycle. Reads that see no rvalid within
//           TIMEOUT_CYCLES complete with all-ones data and set a sticky error.
// Ports   : clk_i        clock
//           rst_n_i      asynchronous active-low reset
//           enable_i     0 blocks new grants; an in-flight transaction finishes
//           bus          gpu_l2_req_responder_if.slave (cluster + back-end bus)
//           busy_o       state != IDLE
//           err_o        sticky timeout flag, cleared only by reset
//           req_count_o  completed transactions, wrapping
module gpu_l2_req_responder #(
  parameter int NUM_CLIENTS    = 2,
  parameter int DATA_W         = 256,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    enable_i,
  gpu_l2_req_responder_if.slave   bus,
  output logic                    busy_o,
  output logic                    err_o,
  output logic [31:0]             req_count_o
);

  localparam int CW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t                        state_r;
  logic [CW-1:0]                 last_grant_r;
  logic [CW-1:0]                 client_r;
  logic [TW-1:0]                 timer_r;
  logic                          mem_req_r;
  logic                          mem_we_r;
  logic [ADDR_W-1:0]             mem_addr_r;
  logic [DATA_W-1:0]             mem_wdata_r;
  logic [NUM_CLIENTS-1:0]        ready_r;
  logic [NUM_CLIENTS*DATA_W-1:0] rdata_r;
  logic                          busy_r;
  logic                          err_r;
  logic [31:0]                   req_count_r;

  logic [NUM_CLIENTS-1:0]        pending_s;
  logic                          grant_valid_s;
  logic [CW-1:0]                 grant_id_s;
  int                            grant_base_s;
  int                            client_base_s;
  logic                          grant_we_s;
  logic [ADDR_W-1:0]             grant_addr_s;
  logic [DATA_W-1:0]             grant_wdata_s;
  logic [NUM_CLIENTS-1:0]        ready_onehot_s;

  // Round-robin pick: on a tie the client that did not win last time goes next.
  always_comb begin
    pending_s     = bus.cl_read_i | bus.cl_write_i;
    grant_valid_s = enable_i && (|pending_s);
    if (pending_s[0] && pending_s[1]) begin
      grant_id_s = ~last_grant_r;
    end else if (pending_s[1]) begin
      grant_id_s = CW'(1);
    end else begin
      grant_id_s = CW'(0);
    end
    grant_base_s   = int'(grant_id_s) * DATA_W;
    client_base_s  = int'(client_r) * DATA_W;
    // Write wins when a client raises read and write together.
    grant_we_s     = bus.cl_write_i[grant_id_s];
    grant_addr_s   = bus.cl_addr_i[grant_base_s +: ADDR_W];
    grant_wdata_s  = bus.cl_wdata_i[grant_base_s +: DATA_W];
    ready_onehot_s = NUM_CLIENTS'(1) << client_r;
  end

  // Transaction FSM; every output is a register updated on the transition
  // that precedes the cycle in which it must be visible.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r      <= IDLE;
      last_grant_r <= CW'(1);
      client_r     <= '0;
      timer_r      <= '0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      ready_r      <= '0;
      rdata_r      <= '0;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
      req_count_r  <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            client_r     <= grant_id_s;
            last_grant_r <= grant_id_s;
            mem_addr_r   <= grant_addr_s;
            mem_wdata_r  <= grant_wdata_s;
            mem_we_r     <= grant_we_s;
            mem_req_r    <= 1'b1;
            busy_r       <= 1'b1;
            state_r      <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.mem_gnt_i) begin
            mem_req_r <= 1'b0;
            if (mem_we_r) begin
              ready_r     <= ready_onehot_s;
              req_count_r <= req_count_r + 32'd1;
              state_r     <= RESPOND;
            end else begin
              timer_r <= '0;
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          // rvalid on the final wait cycle still beats the timeout.
          if (bus.mem_rvalid_i) begin
            rdata_r[client_base_s +: DATA_W] <= bus.mem_rdata_i;
            ready_r     <= ready_onehot_s;
            req_count_r <= req_count_r + 32'd1;
            state_r     <= RESPOND;
          end else if (timer_r == TIMER_LAST) begin
            rdata_r[client_base_s +: DATA_W] <= '1;
            err_r       <= 1'b1;
            ready_r     <= ready_onehot_s;
            req_count_r <= req_count_r + 32'd1;
            state_r     <= RESPOND;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        RESPOND: begin
          // No grant here: the responding client may still be holding its request.
          ready_r <= '0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          mem_req_r <= 1'b0;
          ready_r   <= '0;
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req_o   = mem_req_r;
  assign bus.mem_we_o    = mem_we_r;
  assign bus.mem_addr_o  = mem_addr_r;
  assign bus.mem_wdata_o = mem_wdata_r;
  assign bus.cl_ready_o  = ready_r;
  assign bus.cl_rdata_o  = rdata_r;
  assign busy_o          = busy_r;
  assign err_o           = err_r;
  assign req_count_o     = req_count_r;

endmodule

// File: tb/tb_gpu_l2_req_responder.sv
// Directed bench for gpu_l2_req_responder (TIMEOUT_CYCLES = 16).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_gpu_l2_req_responder;
  localparam int NC = 2;
  localparam int DW = 256;
  localparam int AW = 32;
  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        enable_i;
  logic        busy_o;
  logic        err_o;
  logic [31:0] req_count_o;

  int n_total = 0;
  int n_pass  = 0;

  gpu_l2_req_responder_if #(.NUM_CLIENTS(NC), .DATA_W(DW), .ADDR_W(AW)) bus ();

  gpu_l2_req_responder #(
    .NUM_CLIENTS(NC), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .enable_i(enable_i), .bus(bus),
    .busy_o(busy_o), .err_o(err_o), .req_count_o(req_count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running, expected done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [255:0] rdata_of(input int c);
    return bus.cl_rdata_o[c*DW +: DW];
  endfunction

  initial begin
    logic [255:0] a5_s;
    logic [255:0] ones_s;
    logic [255:0] wd0_s;
    logic [255:0] wd1_s;
    logic [255:0] rd6_s;
    a5_s   = {32{8'hA5}};
    ones_s = {256{1'b1}};
    wd0_s  = {8{32'hC0DE_0000}};
    wd1_s  = {8{32'h0000_C1C1}};
    rd6_s  = {16{16'h1234}};

    rst_n_i          = 1'b0;
    enable_i         = 1'b1;
    bus.cl_read_i    = 2'b00;
    bus.cl_write_i   = 2'b00;
    bus.cl_addr_i    = '0;
    bus.cl_wdata_i   = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    tick();
    tick();
    check("rst_busy",  256'(busy_o), 256'(1'b0));
    check("rst_ready", 256'(bus.cl_ready_o), 256'(2'b00));
    check("rst_req",   256'(bus.mem_req_o), 256'(1'b0));
    check("rst_count", 256'(req_count_o), 256'(32'd0));
    check("rst_err",   256'(err_o), 256'(1'b0));
    @(negedge clk_i);
    rst_n_i = 1'b1;
    tick();

    // T2: single read from client 0, minimum latency
    bus.cl_read_i = 2'b01;
    bus.cl_addr_i[0*DW +: DW] = 256'h100;
    tick();                                            // cycle 1: ISSUE
    check("t2_req",  256'(bus.mem_req_o), 256'(1'b1));
    check("t2_we",   256'(bus.mem_we_o), 256'(1'b0));
    check("t2_addr", 256'(bus.mem_addr_o), 256'(32'h100));
    check("t2_busy", 256'(busy_o), 256'(1'b1));
    bus.mem_gnt_i = 1'b1;
    tick();                                            // cycle 2: WAIT
    check("t2_req_drop", 256'(bus.mem_req_o), 256'(1'b0));
    check("t2_ready_c2", 256'(bus.cl_ready_o), 256'(2'b00));
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = a5_s;
    tick();                                            // cycle 3: RESPOND
    bus.mem_rvalid_i = 1'b0;
    check("t2_ready", 256'(bus.cl_ready_o), 256'(2'b01));
    check("t2_rdata", rdata_of(0), a5_s);
    check("t2_count", 256'(req_count_o), 256'(32'd1));
    bus.cl_read_i = 2'b00;
    tick();
    check("t2_ready_pulse", 256'(bus.cl_ready_o), 256'(2'b00));
    check("t2_idle", 256'(busy_o), 256'(1'b0));

    // T1: asynchronous reset while waiting for read data
    bus.cl_read_i = 2'b01;
    bus.cl_addr_i[0*DW +: DW] = 256'h200;
    tick();
    bus.mem_gnt_i = 1'b1;
    tick();                                            // WAIT
    bus.mem_gnt_i = 1'b0;
    tick();
    check("t1_busy_pre", 256'(busy_o), 256'(1'b1));
    #2;
    rst_n_i = 1'b0;
    #1;
    check("t1_busy_async",  256'(busy_o), 256'(1'b0));
    check("t1_req_async",   256'(bus.mem_req_o), 256'(1'b0));
    check("t1_ready_async", 256'(bus.cl_ready_o), 256'(2'b00));
    check("t1_count_async", 256'(req_count_o), 256'(32'd0));
    bus.cl_read_i = 2'b00;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    tick();
    check("t1_idle",  256'(busy_o), 256'(1'b0));
    check("t1_count", 256'(req_count_o), 256'(32'd0));

    // T3: both clients write and hold; client 0 wins first tie after reset
    bus.cl_write_i = 2'b11;
    bus.cl_addr_i[0*DW +: DW]  = 256'h300;
    bus.cl_addr_i[1*DW +: DW]  = 256'h400;
    bus.cl_wdata_i[0*DW +: DW] = wd0_s;
    bus.cl_wdata_i[1*DW +: DW] = wd1_s;
    tick();                                            // cycle 1
    check("t3_addr0",  256'(bus.mem_addr_o), 256'(32'h300));
    check("t3_we0",    256'(bus.mem_we_o), 256'(1'b1));
    check("t3_wdata0", bus.mem_wdata_o, wd0_s);
    bus.mem_gnt_i = 1'b1;
    tick();                                            // cycle 2
    bus.mem_gnt_i = 1'b0;
    check("t3_ready0", 256'(bus.cl_ready_o), 256'(2'b01));
    tick();                                            // cycle 3: IDLE, both still pending
    check("t3_gap_ready", 256'(bus.cl_ready_o), 256'(2'b00));
    check("t3_gap_req",   256'(bus.mem_req_o), 256'(1'b0));
    tick();                                            // cycle 4: client 1 issued
    check("t3_addr1",  256'(bus.mem_addr_o), 256'(32'h400));
    check("t3_wdata1", bus.mem_wdata_o, wd1_s);
    bus.mem_gnt_i = 1'b1;
    tick();                                            // cycle 5
    bus.mem_gnt_i  = 1'b0;
    bus.cl_write_i = 2'b00;
    check("t3_ready1", 256'(bus.cl_ready_o), 256'(2'b10));
    check("t3_count",  256'(req_count_o), 256'(32'd2));
    tick();

    // T4: back-pressure on gnt, client 1 alone wins
    bus.cl_write_i = 2'b10;
    bus.cl_addr_i[1*DW +: DW] = 256'h500;
    tick();
    for (int i = 0; i < 6; i++) begin
      check("t4_req_addr_stable", 256'({bus.mem_req_o, bus.mem_addr_o}), 256'({1'b1, 32'h500}));
      if (i == 5) bus.mem_gnt_i = 1'b1;
      tick();
    end
    bus.mem_gnt_i  = 1'b0;
    bus.cl_write_i = 2'b00;
    check("t4_ready", 256'(bus.cl_ready_o), 256'(2'b10));
    check("t4_count", 256'(req_count_o), 256'(32'd3));
    tick();

    // T5: read timeout, client 0
    bus.cl_read_i = 2'b01;
    bus.cl_addr_i[0*DW +: DW] = 256'h600;
    tick();
    bus.mem_gnt_i = 1'b1;
    tick();                                            // first WAIT cycle
    bus.mem_gnt_i = 1'b0;
    for (int i = 0; i < TO; i++) begin
      check("t5_wait", 256'({bus.cl_ready_o, err_o}), 256'({2'b00, 1'b0}));
      tick();
    end
    bus.cl_read_i = 2'b00;
    check("t5_ready", 256'(bus.cl_ready_o), 256'(2'b01));
    check("t5_rdata", rdata_of(0), ones_s);
    check("t5_err",   256'(err_o), 256'(1'b1));
    tick();
    check("t5_err_sticky", 256'(err_o), 256'(1'b1));
    check("t5_count", 256'(req_count_o), 256'(32'd4));

    // T6: disabled, stray rvalid in IDLE, then client 1 served
    enable_i      = 1'b0;
    bus.cl_read_i = 2'b10;
    bus.cl_addr_i[1*DW +: DW] = 256'h700;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_req", 256'({bus.mem_req_o, busy_o}), 256'(2'b00));
    end
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = a5_s;
    tick();
    bus.mem_rvalid_i = 1'b0;
    check("t6_stray_ready", 256'(bus.cl_ready_o), 256'(2'b00));
    check("t6_stray_rdata", rdata_of(1), 256'(0));
    enable_i = 1'b1;
    tick();
    check("t6_req",  256'(bus.mem_req_o), 256'(1'b1));
    check("t6_addr", 256'(bus.mem_addr_o), 256'(32'h700));
    bus.mem_gnt_i = 1'b1;
    tick();
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = rd6_s;
    tick();
    bus.mem_rvalid_i = 1'b0;
    bus.cl_read_i    = 2'b00;
    check("t6_ready",  256'(bus.cl_ready_o), 256'(2'b10));
    check("t6_rdata1", rdata_of(1), rd6_s);
    check("t6_rdata0_kept", rdata_of(0), ones_s);
    check("t6_count",  256'(req_count_o), 256'(32'd5));
    check("t6_err",    256'(err_o), 256'(1'b1));
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
